// File: rtl/cpu_run_controller.sv
// Load/run lifecycle sequencer for the single-cycle MIPS core: streams a program
// into instruction memory, then gates PC advance in free-run or single-step mode.
module cpu_run_controller #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    IMEM_DEPTH  = 43,
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD   = 32'hFFFFFFFF,
  parameter int                    CYCLE_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run_switch,
  input  logic                   step_mode,
  input  logic                   step_pulse,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_waddr,
  output logic [DATA_WIDTH-1:0]  imem_wdata,
  input  logic [DATA_WIDTH-1:0]  instr,
  output logic                   pc_reset,
  output logic                   cpu_enable,
  output logic                   halted,
  output logic                   err_overflow,
  output logic [2:0]             state,
  output logic [ADDR_WIDTH:0]    loaded_count,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] READY = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] STEP  = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(IMEM_DEPTH);

  logic [2:0]            next_state;
  logic                  step_q;
  logic                  step_rise;
  logic                  transfer;
  logic                  is_halt;
  logic                  start;
  logic                  enter_load;
  logic [ADDR_WIDTH:0]   count_next;

  assign step_rise  = step_pulse & ~step_q;
  assign load_ready = (state == LOAD);
  assign transfer   = load_ready & load_valid;
  assign is_halt    = (instr == HALT_WORD);
  assign count_next = loaded_count + {{ADDR_WIDTH{1'b0}}, transfer};

  // A word accepted in the same cycle as the start request counts toward the start.
  assign start      = run_switch && (count_next != '0);
  assign enter_load = (state == IDLE) && !run_switch;

  assign imem_we    = transfer;
  assign imem_waddr = loaded_count[ADDR_WIDTH-1:0];
  assign imem_wdata = load_data;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (!run_switch) next_state = LOAD;
      LOAD: begin
        if (start)                          next_state = step_mode ? STEP : RUN;
        else if (count_next == DEPTH_COUNT) next_state = READY;
      end
      READY: if (start) next_state = step_mode ? STEP : RUN;
      RUN: begin
        if (!run_switch)   next_state = IDLE;
        else if (is_halt)  next_state = HALT;
        else if (step_mode) next_state = STEP;
      end
      STEP: begin
        if (!run_switch)    next_state = IDLE;
        else if (is_halt)   next_state = HALT;
        else if (!step_mode) next_state = RUN;
      end
      HALT:  if (!run_switch) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Enable is held off while the PC is still pinned at 0 so instruction 0 runs once.
  always_comb begin
    cpu_enable = 1'b0;
    case (state)
      RUN:     cpu_enable = !pc_reset && !is_halt;
      STEP:    cpu_enable = !pc_reset && step_rise && !is_halt;
      default: cpu_enable = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      step_q       <= 1'b0;
      pc_reset     <= 1'b1;
      halted       <= 1'b0;
      err_overflow <= 1'b0;
      loaded_count <= '0;
      cycle_count  <= '0;
    end else begin
      state    <= next_state;
      step_q   <= step_pulse;
      pc_reset <= (state == IDLE) || (state == LOAD) || (state == READY);

      if (enter_load) begin
        loaded_count <= '0;
        halted       <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (transfer)                        loaded_count <= count_next;
        if ((state == READY) && load_valid)  err_overflow <= 1'b1;
        if ((state != HALT) && (next_state == HALT)) halted <= 1'b1;
      end

      if (((state == LOAD) || (state == READY)) && ((next_state == RUN) || (next_state == STEP)))
        cycle_count <= '0;
      else if (cpu_enable && !(&cycle_count))
        cycle_count <= cycle_count + {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule
